// File: rtl/cpu_event_tracer_pkg.sv
// rtl/cpu_event_tracer_pkg.sv - shared constants and entry layout for the CPU event tracer
package cpu_event_tracer_pkg;

  localparam int TRACE_DROP_W    = 16;
  localparam int TRACE_ID_W      = 3;
  localparam int TRACE_TS_W      = 32;
  localparam int TRACE_PAYLOAD_W = 32;

  // Entry layout at the default sizes; other parameterisations use flat vectors
  typedef struct packed {
    logic [TRACE_ID_W-1:0]      id;
    logic [TRACE_TS_W-1:0]      ts;
    logic [TRACE_PAYLOAD_W-1:0] payload;
  } trace_entry_t;

endpackage

// File: rtl/cpu_event_tracer_fifo.sv
// rtl/cpu_event_tracer_fifo.sv - synchronous first-word-fall-through FIFO holding trace entries
module trace_fifo
  import cpu_event_tracer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == (AW+1)'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_level <= r_level + (AW+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_level <= r_level - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_event_tracer.sv
// rtl/cpu_event_tracer.sv - timestamps masked CPU event lines and queues them for a valid/ready dumper
module cpu_event_tracer
  import cpu_event_tracer_pkg::*;
#(
  parameter int                    NUM_EVENTS = 8,
  parameter int                    PAYLOAD_W  = 32,
  parameter int                    DEPTH      = 16,
  parameter int                    TS_W       = 32,
  parameter logic [NUM_EVENTS-1:0] LEVEL_MASK = '0,
  localparam int                   IDW        = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  localparam int                   LVW        = $clog2(DEPTH) + 1
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_enable,
  input  logic                            i_clear_stats,
  input  logic [NUM_EVENTS-1:0]           i_event_mask,
  input  logic [NUM_EVENTS-1:0]           i_event_in,
  input  logic [NUM_EVENTS*PAYLOAD_W-1:0] i_payload_in,
  output logic                            o_trace_valid,
  input  logic                            i_trace_ready,
  output logic [IDW-1:0]                  o_trace_id,
  output logic [TS_W-1:0]                 o_trace_ts,
  output logic [PAYLOAD_W-1:0]            o_trace_payload,
  output logic [LVW-1:0]                  o_fifo_level,
  output logic [TRACE_DROP_W-1:0]         o_drop_count,
  output logic                            o_overflow
);

  localparam int EW = IDW + TS_W + PAYLOAD_W;

  logic [TS_W-1:0]         r_ts;
  logic [NUM_EVENTS-1:0]   r_event_q;
  logic [NUM_EVENTS-1:0]   r_pending;
  logic [PAYLOAD_W-1:0]    r_hold_payload [NUM_EVENTS];
  logic [TS_W-1:0]         r_hold_ts      [NUM_EVENTS];
  logic [TRACE_DROP_W-1:0] r_drop_count;
  logic                    r_overflow;

  logic [NUM_EVENTS-1:0]   w_rise;
  logic [NUM_EVENTS-1:0]   w_hit;
  logic [NUM_EVENTS-1:0]   w_grant;
  logic [NUM_EVENTS-1:0]   w_drop;
  logic [IDW-1:0]          w_grant_idx;
  logic                    w_any_pending;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [EW-1:0]           w_push_data;
  logic [EW-1:0]           w_head;
  logic [TRACE_DROP_W:0]   w_ndrop;
  logic [TRACE_DROP_W:0]   w_drop_sum;

  assign w_rise = i_event_in & (~r_event_q | LEVEL_MASK);
  assign w_hit  = w_rise & i_event_mask & {NUM_EVENTS{i_enable}};
  assign w_pop  = ~w_empty & i_trace_ready;

  always_comb begin
    w_grant_idx   = '0;
    w_any_pending = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (r_pending[i] && !w_any_pending) begin
        w_grant_idx   = IDW'(i);
        w_any_pending = 1'b1;
      end
    end
  end

  assign w_push      = w_any_pending & (~w_full | w_pop);
  assign w_grant     = w_push ? (NUM_EVENTS'(1) << w_grant_idx) : '0;
  // A granted channel hands its old entry to the FIFO, so a same-cycle hit is not a loss
  assign w_drop      = w_hit & r_pending & ~w_grant;
  assign w_push_data = {w_grant_idx, r_hold_ts[w_grant_idx], r_hold_payload[w_grant_idx]};

  always_comb begin
    w_ndrop = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      w_ndrop = w_ndrop + (TRACE_DROP_W+1)'(w_drop[i]);
    end
    w_drop_sum = {1'b0, r_drop_count} + w_ndrop;
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (w_hit[i]) begin
        r_hold_payload[i] <= i_payload_in[i*PAYLOAD_W +: PAYLOAD_W];
        r_hold_ts[i]      <= r_ts;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ts         <= '0;
      r_event_q    <= '0;
      r_pending    <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_ts      <= r_ts + TS_W'(1);
      r_event_q <= i_event_in;
      r_pending <= (r_pending & ~w_grant) | w_hit;
      if (i_clear_stats) begin
        r_drop_count <= '0;
        r_overflow   <= 1'b0;
      end else if (|w_drop) begin
        r_drop_count <= w_drop_sum[TRACE_DROP_W] ? '1 : w_drop_sum[TRACE_DROP_W-1:0];
        r_overflow   <= 1'b1;
      end
    end
  end

  trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_fifo_level)
  );

  assign o_trace_valid   = ~w_empty;
  assign o_trace_id      = w_empty ? '0 : w_head[EW-1 -: IDW];
  assign o_trace_ts      = w_empty ? '0 : w_head[PAYLOAD_W +: TS_W];
  assign o_trace_payload = w_empty ? '0 : w_head[PAYLOAD_W-1:0];
  assign o_drop_count    = r_drop_count;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_cpu_event_tracer.sv
// tb/tb_cpu_event_tracer.sv - directed bench for cpu_event_tracer, edge-mode and level-on-ch0 instances
module tb_cpu_event_tracer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, enable, clear_stats, trace_ready;
  logic [7:0]   event_mask, event_in;
  logic [255:0] payload_in;

  logic        e_valid, l_valid, e_ovf, l_ovf;
  logic [2:0]  e_id, l_id;
  logic [31:0] e_ts, l_ts, e_pl, l_pl;
  logic [4:0]  e_level, l_level;
  logic [15:0] e_drop, l_drop;

  int checks = 0;
  int errors = 0;

  cpu_event_tracer #(.NUM_EVENTS(8), .PAYLOAD_W(32), .DEPTH(16), .TS_W(32), .LEVEL_MASK(8'h00)) dut_e (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear_stats(clear_stats),
    .i_event_mask(event_mask), .i_event_in(event_in), .i_payload_in(payload_in),
    .o_trace_valid(e_valid), .i_trace_ready(trace_ready), .o_trace_id(e_id),
    .o_trace_ts(e_ts), .o_trace_payload(e_pl), .o_fifo_level(e_level),
    .o_drop_count(e_drop), .o_overflow(e_ovf)
  );

  cpu_event_tracer #(.NUM_EVENTS(8), .PAYLOAD_W(32), .DEPTH(16), .TS_W(32), .LEVEL_MASK(8'h01)) dut_l (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_clear_stats(clear_stats),
    .i_event_mask(event_mask), .i_event_in(event_in), .i_payload_in(payload_in),
    .o_trace_valid(l_valid), .i_trace_ready(trace_ready), .o_trace_id(l_id),
    .o_trace_ts(l_ts), .o_trace_payload(l_pl), .o_fifo_level(l_level),
    .o_drop_count(l_drop), .o_overflow(l_ovf)
  );

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] ts;
    logic [31:0] pl;
  } ent_t;

  // Reference: a queue of entries plus one held event per channel
  ent_t        mq [2][$];
  logic [7:0]  m_pend [2];
  logic [31:0] m_hts  [2][8];
  logic [31:0] m_hpl  [2][8];
  logic [31:0] m_ts   [2];
  logic [7:0]  m_evq  [2];
  int          m_drop [2];
  logic        m_ovf  [2];
  bit          started = 0;
  int          tb_ts = 0;

  task automatic step(input int k);
    logic [7:0] lm, hit;
    bit         pop, room;
    int         g;
    ent_t       e;
    lm = (k == 1) ? 8'h01 : 8'h00;
    g  = -1;
    if (reset) begin
      mq[k].delete();
      m_pend[k] = '0; m_ts[k] = '0; m_evq[k] = '0; m_drop[k] = 0; m_ovf[k] = 1'b0;
      return;
    end
    hit  = event_in & (~m_evq[k] | lm) & event_mask & {8{enable}};
    pop  = (mq[k].size() > 0) && trace_ready;
    room = (mq[k].size() < 16) || pop;
    if (pop) void'(mq[k].pop_front());
    if (room) begin
      for (int i = 0; i < 8; i++) if (m_pend[k][i] && g < 0) g = i;
    end
    if (g >= 0) begin
      e.id = 3'(g); e.ts = m_hts[k][g]; e.pl = m_hpl[k][g];
      mq[k].push_back(e);
      m_pend[k][g] = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (hit[i]) begin
        if (m_pend[k][i]) begin
          if (m_drop[k] < 65535) m_drop[k]++;
          m_ovf[k] = 1'b1;
        end
        m_pend[k][i] = 1'b1;
        m_hts[k][i]  = m_ts[k];
        m_hpl[k][i]  = payload_in[i*32 +: 32];
      end
    end
    if (clear_stats) begin
      m_drop[k] = 0;
      m_ovf[k]  = 1'b0;
    end
    m_evq[k] = event_in;
    m_ts[k]  = m_ts[k] + 1;
  endtask

  always @(posedge clk) begin
    step(0);
    step(1);
    tb_ts   = reset ? 0 : tb_ts + 1;
    started = 1;
  end

  task automatic cmp(input int k, input logic v, input logic [2:0] id, input logic [31:0] ts,
                     input logic [31:0] pl, input logic [4:0] lv, input logic [15:0] dc, input logic ov);
    logic [89:0] act, exp;
    ent_t        h;
    h   = (mq[k].size() > 0) ? mq[k][0] : '0;
    exp = {mq[k].size() > 0, h.id, h.ts, h.pl, 5'(mq[k].size()), 16'(m_drop[k]), m_ovf[k]};
    act = {v, id, ts, pl, lv, dc, ov};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp dut%0d t=%0t got=%h expected=%h", k, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp(0, e_valid, e_id, e_ts, e_pl, e_level, e_drop, e_ovf);
      cmp(1, l_valid, l_id, l_ts, l_pl, l_level, l_drop, l_ovf);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pl(input int ch, input logic [31:0] v);
    payload_in[ch*32 +: 32] = v;
  endtask

  int fire_ts;

  initial begin
    reset = 1'b1; enable = 1'b1; clear_stats = 1'b0; trace_ready = 1'b1;
    event_mask = 8'hFF; event_in = 8'h00; payload_in = '0;
    tick();
    chk("reset_valid", 64'(e_valid), 64'd0);
    chk("reset_level", 64'(l_level), 64'd0);
    chk("reset_drop", 64'(e_drop), 64'd0);
    tick();
    reset = 1'b0;

    // 1: single pulse on ch3 in the ts=10 cycle
    tick(10);
    event_in = 8'h08; set_pl(3, 32'hDEADBEEF);
    tick();
    event_in = 8'h00;
    chk("t1_valid_early", 64'(e_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(e_valid), 64'd1);
    chk("t1_id", 64'(e_id), 64'd3);
    chk("t1_ts", 64'(e_ts), 64'd10);
    chk("t1_payload", 64'(e_pl), 64'hDEADBEEF);
    tick(3);

    // 2: ch0 high for 20 cycles, consumer stalled
    trace_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      event_in = 8'h01; set_pl(0, 32'hA000 + 32'(k));
      tick();
    end
    event_in = 8'h00;
    tick(3);
    chk("t2_edge_level", 64'(e_level), 64'd1);
    chk("t2_edge_drop", 64'(e_drop), 64'd0);
    chk("t2_lvl_level", 64'(l_level), 64'd16);
    chk("t2_lvl_drop", 64'(l_drop), 64'd3);
    chk("t2_lvl_ovf", 64'(l_ovf), 64'd1);
    chk("t2_lvl_head", 64'(l_pl), 64'hA000);
    trace_ready = 1'b1;
    tick(22);
    chk("t2_drained", 64'(l_level), 64'd0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t5_clear_drop", 64'(l_drop), 64'd0);
    chk("t5_clear_ovf", 64'(l_ovf), 64'd0);

    // 3: channels 5, 1, 6 rise together
    trace_ready = 1'b0;
    event_in = 8'h62; set_pl(1, 32'h11); set_pl(5, 32'h55); set_pl(6, 32'h66);
    fire_ts = tb_ts;
    tick();
    event_in = 8'h00;
    tick(3);
    chk("t3_level", 64'(e_level), 64'd3);
    chk("t3_id0", 64'(e_id), 64'd1);
    chk("t3_ts0", 64'(e_ts), 64'(fire_ts));
    trace_ready = 1'b1;
    tick();
    chk("t3_id1", 64'(e_id), 64'd5);
    chk("t3_ts1", 64'(e_ts), 64'(fire_ts));
    tick();
    chk("t3_id2", 64'(e_id), 64'd6);
    chk("t3_pl2", 64'(e_pl), 64'h66);
    tick();
    chk("t3_empty", 64'(e_valid), 64'd0);
    chk("t3_drop", 64'(e_drop), 64'd0);

    // 4: fill to 16, then stream one in / one out per cycle
    trace_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      event_in = 8'(1 << (1 + i % 7)); set_pl(1 + i % 7, 32'h1000 + 32'(i));
      tick();
      event_in = 8'h00;
      tick();
    end
    chk("t4_full", 64'(e_level), 64'd16);
    chk("t4_head", 64'(e_pl), 64'h1000);
    event_in = 8'h02; set_pl(1, 32'h2000);
    tick();
    for (int j = 0; j < 10; j++) begin
      trace_ready = 1'b1;
      event_in = (j % 2 == 0) ? 8'h04 : 8'h02;
      set_pl((j % 2 == 0) ? 2 : 1, 32'h2001 + 32'(j));
      tick();
      chk("t4_stream_level", 64'(e_level), 64'd16);
      if (j == 0) chk("t4_order", 64'(e_pl), 64'h1001);
    end
    event_in = 8'h00;
    tick(20);
    chk("t4_drained", 64'(e_level), 64'd0);
    chk("t4_drop", 64'(e_drop), 64'd0);

    // 5: disabled and masked toggling
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin event_in = 8'(i % 2 == 0); tick(); end
    enable = 1'b1; event_mask = 8'hFE;
    for (int i = 0; i < 6; i++) begin event_in = 8'(i % 2 == 0); tick(); end
    event_mask = 8'hFF; event_in = 8'h00;
    tick(3);
    chk("t5_none_e", 64'(e_level), 64'd0);
    chk("t5_none_l", 64'(l_level), 64'd0);

    // 6: reset with 8 entries and 2 pending
    trace_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      event_in = 8'(1 << i); set_pl(i, 32'h3000 + 32'(i));
      tick();
      event_in = 8'h00;
      tick();
    end
    event_in = 8'h0E;
    tick();
    event_in = 8'h00;
    tick();
    chk("t6_level8", 64'(e_level), 64'd8);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(e_valid), 64'd0);
    chk("t6_rst_level", 64'(l_level), 64'd0);
    reset = 1'b0;
    event_in = 8'h20; set_pl(5, 32'h5555);
    tick();
    event_in = 8'h00;
    tick(3);
    chk("t6_only_one", 64'(e_level), 64'd1);
    chk("t6_id", 64'(e_id), 64'd5);
    chk("t6_ts0", 64'(e_ts), 64'd0);
    chk("t6_payload", 64'(e_pl), 64'h5555);
    trace_ready = 1'b1;
    tick(3);
    chk("t6_drained", 64'(l_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
